// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS sequencer: opcode/funct values,
// ALU operation encodings, sequencer state encodings and instruction classes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_AND  = 4'b0001,
        ALU_NOR  = 4'b0011,
        ALU_OR   = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SUB  = 4'b0111,
        ALU_SUBU = 4'b1000,
        ALU_NONE = 4'b1111
    } alu_op_e;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_MEM    = 4'd4,
        ST_WB     = 4'd5,
        ST_JUMP   = 4'd6,
        ST_TRAP   = 4'd7
    } seq_state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_ITYPE,
        CLS_LOAD,
        CLS_STORE,
        CLS_JUMP,
        CLS_ILLEGAL
    } instr_class_e;

    function automatic logic is_mem_class(input instr_class_e c);
        return (c == CLS_LOAD) || (c == CLS_STORE);
    endfunction

endpackage

// File: rtl/mips_seq_decode.sv
// Combinational instruction decoder: maps opcode/funct to an instruction
// class and the datapath controls that depend only on the instruction.
module mips_seq_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_e iclass,
    output alu_op_e      alu_op,
    output logic         alu_src,
    output logic         reg_dst,
    output logic         mem_to_reg,
    output logic         legal
);

    // Class and ALU operation lookup; anything unlisted is illegal.
    always_comb begin
        iclass = CLS_ILLEGAL;
        alu_op = ALU_NONE;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin iclass = CLS_RTYPE; alu_op = ALU_ADD;  end
                    FN_SUB:  begin iclass = CLS_RTYPE; alu_op = ALU_SUB;  end
                    FN_SUBU: begin iclass = CLS_RTYPE; alu_op = ALU_SUBU; end
                    FN_AND:  begin iclass = CLS_RTYPE; alu_op = ALU_AND;  end
                    FN_OR:   begin iclass = CLS_RTYPE; alu_op = ALU_OR;   end
                    FN_NOR:  begin iclass = CLS_RTYPE; alu_op = ALU_NOR;  end
                    FN_SLT:  begin iclass = CLS_RTYPE; alu_op = ALU_SLT;  end
                    FN_JR:   iclass = CLS_JUMP;
                    default: iclass = CLS_ILLEGAL;
                endcase
            end
            OP_J:    iclass = CLS_JUMP;
            OP_ADDI: begin iclass = CLS_ITYPE; alu_op = ALU_ADD; end
            OP_ANDI: begin iclass = CLS_ITYPE; alu_op = ALU_AND; end
            OP_ORI:  begin iclass = CLS_ITYPE; alu_op = ALU_OR;  end
            OP_SLTI: begin iclass = CLS_ITYPE; alu_op = ALU_SLT; end
            OP_LW:   begin iclass = CLS_LOAD;  alu_op = ALU_ADD; end
            OP_SW:   begin iclass = CLS_STORE; alu_op = ALU_ADD; end
            default: iclass = CLS_ILLEGAL;
        endcase
    end

    assign alu_src    = (iclass == CLS_ITYPE) || is_mem_class(iclass);
    assign reg_dst    = (iclass == CLS_RTYPE);
    assign mem_to_reg = (iclass == CLS_LOAD);
    assign legal      = (iclass != CLS_ILLEGAL);

endmodule

// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle control FSM for the MIPS datapath. One shared memory port
// serves instruction fetch and lw/sw data accesses.
// Optional retired-instruction counter: define MIPS_SEQ_INSTR_COUNT_EN.
//
// state  | meaning
// IDLE   | stopped at an instruction boundary, waiting for run
// FETCH  | read instruction at PC; IR/PC load on mem_ready
// DECODE | register read, latch opcode/funct, pick the path
// EXEC   | ALU operation
// MEM    | lw/sw data access, held until mem_ready
// WB     | register file write, retire
// JUMP   | load jump target into PC, retire
// TRAP   | illegal instruction or memory timeout; left only by reset
//
// The wait counter counts stalled cycles in FETCH/MEM. The cycle on which it
// equals MEM_WAIT_MAX is the last chance: mem_ready there completes normally,
// otherwise the FSM traps with timeout set.
module mips_multicycle_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int WAIT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Function,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegRead,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        ALUsrc,
    output logic        MemtoReg,
    output logic        Muxif,
    output logic [3:0]  ALU_Op,
    output logic [3:0]  state,
    output logic        busy,
    output logic        illegal,
    output logic        timeout,
    output logic [31:0] retired_cnt
);

    seq_state_e        state_q, state_d;
    logic [5:0]        op_q, fn_q;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;
    logic              wait_limit;

    logic [5:0]        dec_op, dec_fn;
    instr_class_e      iclass;
    alu_op_e           dec_alu_op;
    logic              dec_alu_src, dec_reg_dst, dec_mem_to_reg, dec_legal;

    // DECODE looks at the live IR; later states use the copy latched there.
    assign dec_op = (state_q == ST_DECODE) ? Opcode   : op_q;
    assign dec_fn = (state_q == ST_DECODE) ? Function : fn_q;

    mips_seq_decode u_decode (
        .opcode     (dec_op),
        .funct      (dec_fn),
        .iclass     (iclass),
        .alu_op     (dec_alu_op),
        .alu_src    (dec_alu_src),
        .reg_dst    (dec_reg_dst),
        .mem_to_reg (dec_mem_to_reg),
        .legal      (dec_legal)
    );

    assign wait_limit = (wait_q == WAIT_W'(MEM_WAIT_MAX));

    // State, latched instruction fields, wait counter and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            fn_q      <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            if (state_q == ST_DECODE) begin
                op_q <= Opcode;
                fn_q <= Function;
            end
        end
    end

    // Next-state and Moore output decode; IRWrite/PCWrite in FETCH follow mem_ready.
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        RegRead   = 1'b0;
        RegWrite  = 1'b0;
        RegDst    = 1'b0;
        ALUsrc    = 1'b0;
        MemtoReg  = 1'b0;
        Muxif     = 1'b0;
        ALU_Op    = ALU_NONE;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_limit) begin
                    state_d   = ST_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_DECODE: begin
                RegRead = 1'b1;
                if (!dec_legal) begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end else if (iclass == CLS_JUMP) begin
                    state_d = ST_JUMP;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ALU_Op  = dec_alu_op;
                ALUsrc  = dec_alu_src;
                state_d = is_mem_class(iclass) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                IorD     = 1'b1;
                ALU_Op   = dec_alu_op;
                MemRead  = (iclass == CLS_LOAD);
                MemWrite = (iclass == CLS_STORE);
                if (mem_ready) begin
                    if (iclass == CLS_LOAD) state_d = ST_WB;
                    else                    state_d = run ? ST_FETCH : ST_IDLE;
                end else if (wait_limit) begin
                    state_d   = ST_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_WB: begin
                RegWrite = 1'b1;
                RegDst   = dec_reg_dst;
                MemtoReg = dec_mem_to_reg;
                ALU_Op   = dec_alu_op;
                state_d  = run ? ST_FETCH : ST_IDLE;
            end
            ST_JUMP: begin
                Muxif   = 1'b1;
                PCWrite = 1'b1;
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign state   = state_q;
    assign busy    = (state_q != ST_IDLE) && (state_q != ST_TRAP);
    assign illegal = illegal_q;
    assign timeout = timeout_q;

`ifdef MIPS_SEQ_INSTR_COUNT_EN
    logic        retire;
    logic [31:0] retired_q;

    assign retire = (state_q == ST_WB) || (state_q == ST_JUMP) ||
                    ((state_q == ST_MEM) && mem_ready && (iclass == CLS_STORE));

    // Saturating count of retired instructions.
    always_ff @(posedge clk) begin
        if (reset)                             retired_q <= '0;
        else if (retire && (retired_q != '1))  retired_q <= retired_q + 32'd1;
    end

    assign retired_cnt = retired_q;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Self-checking bench for mips_multicycle_sequencer. Each instruction is
// expanded into an expected per-cycle trace from the sequencing rules
// (fetch waits, decode, exec, mem waits, write-back/jump, retire), the trace
// is played into the DUT, and the observed outputs are compared per cycle.
module tb_mips_multicycle_sequencer;

    localparam int WMAX = 4;
    localparam int NI   = 15;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_J = 4;

    localparam logic [3:0] A_NONE = 4'hF;
    localparam logic [3:0] A_ADD  = 4'h0;

    localparam logic [10:0] PCW  = 11'h400;
    localparam logic [10:0] IRW  = 11'h200;
    localparam logic [10:0] IORD = 11'h100;
    localparam logic [10:0] MRD  = 11'h080;
    localparam logic [10:0] MWR  = 11'h040;
    localparam logic [10:0] RRD  = 11'h020;
    localparam logic [10:0] RWR  = 11'h010;
    localparam logic [10:0] RDST = 11'h008;
    localparam logic [10:0] ASRC = 11'h004;
    localparam logic [10:0] MTR  = 11'h002;
    localparam logic [10:0] MUX  = 11'h001;

    // add sub subu and or nor slt addi andi ori slti lw sw j jr
    localparam logic [5:0] T_OP [NI] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                         6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h23, 6'h2b, 6'h02, 6'h00};
    localparam logic [5:0] T_FN [NI] = '{6'h20, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2a,
                                         6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08};
    localparam logic [3:0] T_ALU [NI] = '{4'b0000, 4'b0111, 4'b1000, 4'b0001, 4'b0100, 4'b0011, 4'b0101,
                                          4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0000, 4'b0000, 4'b1111, 4'b1111};
    localparam int T_KIND [NI] = '{K_R, K_R, K_R, K_R, K_R, K_R, K_R,
                                   K_I, K_I, K_I, K_I, K_LW, K_SW, K_J, K_J};

    logic        clk = 1'b0;
    logic        reset, run, mem_ready;
    logic [5:0]  Opcode, Function;
    logic        PCWrite, IRWrite, IorD, MemRead, MemWrite, RegRead, RegWrite;
    logic        RegDst, ALUsrc, MemtoReg, Muxif, busy, illegal, timeout;
    logic [3:0]  ALU_Op, state;
    logic [31:0] retired_cnt;
    logic [21:0] obs;

    mips_multicycle_sequencer #(.MEM_WAIT_MAX(WMAX), .WAIT_W(8)) dut (
        .clk(clk), .reset(reset), .run(run), .Opcode(Opcode), .Function(Function),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegRead(RegRead), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUsrc(ALUsrc), .MemtoReg(MemtoReg), .Muxif(Muxif),
        .ALU_Op(ALU_Op), .state(state), .busy(busy), .illegal(illegal),
        .timeout(timeout), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {state, PCWrite, IRWrite, IorD, MemRead, MemWrite, RegRead, RegWrite,
                  RegDst, ALUsrc, MemtoReg, Muxif, ALU_Op, busy, illegal, timeout};

    typedef struct {
        logic [21:0] exp;
        logic [31:0] cnt;
        logic        rdy;
        logic        rn;
        logic        dec;
        logic [5:0]  op;
        logic [5:0]  fn;
    } cyc_t;

    cyc_t        trace[$];
    logic [21:0] obs_q[$];
    logic [31:0] cnt_q[$];
    logic [31:0] model_cnt;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [21:0] ev(input logic [3:0] st, input logic [10:0] s,
                                       input logic [3:0] alu, input logic ill, input logic tmo);
        logic bsy;
        bsy = (st != 4'd0) && (st != 4'd7);
        return {st, s, alu, bsy, ill, tmo};
    endfunction

    function automatic bit tb_legal(input logic [5:0] op, input logic [5:0] fn);
        for (int i = 0; i < NI; i++)
            if (T_OP[i] == op && (op != 6'h00 || T_FN[i] == fn)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_cyc(input logic [21:0] e, input logic rdy, input logic rn,
                            input logic dec, input logic [5:0] op, input logic [5:0] fn);
        cyc_t c;
        c.exp = e; c.cnt = model_cnt; c.rdy = rdy; c.rn = rn; c.dec = dec; c.op = op; c.fn = fn;
        trace.push_back(c);
    endtask

    task automatic count_retire();
`ifdef MIPS_SEQ_INSTR_COUNT_EN
        if (model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
`endif
    endtask

    // Expected trace of one instruction with wf fetch stalls and wm data stalls.
    task automatic build_instr(input int idx, input int wf, input int wm,
                               input logic run_fetch, input logic run_body);
        logic [5:0]  op, fn;
        logic [3:0]  a;
        logic [10:0] ms;
        int          k;
        op = T_OP[idx];
        fn = (op == 6'h00) ? T_FN[idx] : 6'($urandom);
        a  = T_ALU[idx];
        k  = T_KIND[idx];
        for (int i = 0; i < wf; i++) push_cyc(ev(1, MRD, A_NONE, 0, 0), 1'b0, run_fetch, 0, op, fn);
        push_cyc(ev(1, MRD | PCW | IRW, A_NONE, 0, 0), 1'b1, run_fetch, 0, op, fn);
        push_cyc(ev(2, RRD, A_NONE, 0, 0), 1'($urandom), run_fetch, 1, op, fn);
        if (k == K_J) begin
            push_cyc(ev(6, MUX | PCW, A_NONE, 0, 0), 1'($urandom), run_body, 0, op, fn);
            count_retire();
        end else begin
            push_cyc(ev(3, (k == K_R) ? 11'h000 : ASRC, a, 0, 0), 1'($urandom), run_body, 0, op, fn);
            if (k == K_LW || k == K_SW) begin
                ms = IORD | ((k == K_LW) ? MRD : MWR);
                for (int i = 0; i < wm; i++) push_cyc(ev(4, ms, a, 0, 0), 1'b0, run_body, 0, op, fn);
                push_cyc(ev(4, ms, a, 0, 0), 1'b1, run_body, 0, op, fn);
                if (k == K_SW) count_retire();
            end
            if (k != K_SW) begin
                push_cyc(ev(5, RWR | ((k == K_R) ? RDST : 11'h000) | ((k == K_LW) ? MTR : 11'h000), a, 0, 0),
                         1'($urandom), run_body, 0, op, fn);
                count_retire();
            end
        end
        if (!run_body) push_cyc(ev(0, 0, A_NONE, 0, 0), 1'($urandom), 1'b0, 0, op, fn);
    endtask

    // Drives the trace one cycle at a time and records what the DUT shows.
    task automatic play();
        obs_q.delete();
        cnt_q.delete();
        foreach (trace[i]) begin
            @(negedge clk);
            mem_ready = trace[i].rdy;
            run       = trace[i].rn;
            if (trace[i].dec) begin
                Opcode   = trace[i].op;
                Function = trace[i].fn;
            end else begin
                Opcode   = 6'($urandom);
                Function = 6'($urandom);
            end
            #1;
            obs_q.push_back(obs);
            cnt_q.push_back(retired_cnt);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; run = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        trace.delete();
        model_cnt = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; run = 1'b1; mem_ready = 1'b1; Opcode = 6'h23; Function = 6'h20;
        @(negedge clk);
        #1;
        checks++;
        if (obs !== ev(0, 0, A_NONE, 0, 0)) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, ev(0, 0, A_NONE, 0, 0));
        end
        checks++;
        if (retired_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", retired_cnt);
        end
        reset = 1'b0; run = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (obs !== ev(0, 0, A_NONE, 0, 0)) begin
            errors++;
            $display("FAIL idle_hold: got %h expected %h", obs, ev(0, 0, A_NONE, 0, 0));
        end
    endtask

    task automatic test_directed();
        string nm [4] = '{"add", "lw_waits", "sw_run_drop", "jump"};
        int    ix [4] = '{0, 11, 12, 13};
        int    wf [4] = '{0, 2, 0, 0};
        int    wm [4] = '{0, 2, 1, 0};
        logic  rb [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int s = 0; s < 4; s++) begin
            do_reset();
            push_cyc(ev(0, 0, A_NONE, 0, 0), 1'b0, 1'b1, 0, 6'h00, 6'h00);
            build_instr(ix[s], wf[s], wm[s], 1'b1, rb[s]);
            if (rb[s]) push_cyc(ev(1, MRD, A_NONE, 0, 0), 1'b0, 1'b1, 0, 6'h00, 6'h00);
            play();
            foreach (trace[i]) begin
                checks++;
                if (obs_q[i] !== trace[i].exp) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got %h expected %h", nm[s], i, obs_q[i], trace[i].exp);
                end
                checks++;
                if (cnt_q[i] !== trace[i].cnt) begin
                    errors++;
                    $display("FAIL %s_count cycle %0d: got %0d expected %0d", nm[s], i, cnt_q[i], trace[i].cnt);
                end
            end
        end
    endtask

    task automatic test_random();
        bit   in_idle;
        logic rb;
        do_reset();
        in_idle = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (in_idle) push_cyc(ev(0, 0, A_NONE, 0, 0), 1'($urandom), 1'b1, 0, 6'h00, 6'h00);
            rb = (n == 39) ? 1'b0 : ($urandom_range(0, 4) != 0);
            build_instr($urandom_range(0, NI - 1), $urandom_range(0, WMAX), $urandom_range(0, WMAX), 1'b1, rb);
            in_idle = !rb;
        end
        play();
        foreach (trace[i]) begin
            checks++;
            if (obs_q[i] !== trace[i].exp) begin
                errors++;
                $display("FAIL random cycle %0d: got %h expected %h", i, obs_q[i], trace[i].exp);
            end
            checks++;
            if (cnt_q[i] !== trace[i].cnt) begin
                errors++;
                $display("FAIL random_count cycle %0d: got %0d expected %0d", i, cnt_q[i], trace[i].cnt);
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] op, fn;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            op = (r == 0) ? 6'h3f : 6'h00;
            fn = 6'($urandom);
            for (int t = 0; t < 200 && tb_legal(op, fn); t++) begin
                op = ($urandom_range(0, 1) != 0) ? 6'h00 : 6'($urandom);
                fn = 6'($urandom);
            end
            if (tb_legal(op, fn)) begin op = 6'h3f; fn = 6'h00; end
            push_cyc(ev(0, 0, A_NONE, 0, 0), 1'b0, 1'b1, 0, op, fn);
            for (int i = 0; i < r; i++) push_cyc(ev(1, MRD, A_NONE, 0, 0), 1'b0, 1'b1, 0, op, fn);
            push_cyc(ev(1, MRD | PCW | IRW, A_NONE, 0, 0), 1'b1, 1'b1, 0, op, fn);
            push_cyc(ev(2, RRD, A_NONE, 0, 0), 1'b0, 1'b1, 1, op, fn);
            for (int i = 0; i < 4; i++) push_cyc(ev(7, 0, A_NONE, 1, 0), 1'($urandom), 1'(i), 0, op, fn);
            play();
            foreach (trace[i]) begin
                checks++;
                if (obs_q[i] !== trace[i].exp) begin
                    errors++;
                    $display("FAIL illegal op=%h fn=%h cycle %0d: got %h expected %h", op, fn, i, obs_q[i], trace[i].exp);
                end
            end
            do_reset();
            #1;
            checks++;
            if (obs !== ev(0, 0, A_NONE, 0, 0)) begin
                errors++;
                $display("FAIL illegal_reset: got %h expected %h", obs, ev(0, 0, A_NONE, 0, 0));
            end
        end
    endtask

    task automatic test_timeout();
        // FETCH never answered, then answered on the limit cycle, then MEM never answered.
        for (int s = 0; s < 4; s++) begin
            do_reset();
            push_cyc(ev(0, 0, A_NONE, 0, 0), 1'b0, 1'b1, 0, 6'h00, 6'h00);
            if (s == 0) begin
                for (int i = 0; i <= WMAX; i++) push_cyc(ev(1, MRD, A_NONE, 0, 0), 1'b0, 1'b1, 0, 6'h00, 6'h00);
                for (int i = 0; i < 3; i++) push_cyc(ev(7, 0, A_NONE, 0, 1), 1'($urandom), 1'($urandom), 0, 6'h00, 6'h00);
            end else if (s == 1) begin
                build_instr(0, WMAX, 0, 1'b1, 1'b0);
            end else if (s == 2) begin
                build_instr(12, 0, WMAX, 1'b1, 1'b0);
            end else begin
                push_cyc(ev(1, MRD | PCW | IRW, A_NONE, 0, 0), 1'b1, 1'b1, 0, 6'h23, 6'h00);
                push_cyc(ev(2, RRD, A_NONE, 0, 0), 1'b0, 1'b1, 1, 6'h23, 6'h00);
                push_cyc(ev(3, ASRC, A_ADD, 0, 0), 1'b0, 1'b1, 0, 6'h23, 6'h00);
                for (int i = 0; i <= WMAX; i++) push_cyc(ev(4, IORD | MRD, A_ADD, 0, 0), 1'b0, 1'b1, 0, 6'h23, 6'h00);
                for (int i = 0; i < 2; i++) push_cyc(ev(7, 0, A_NONE, 0, 1), 1'($urandom), 1'b1, 0, 6'h23, 6'h00);
            end
            play();
            foreach (trace[i]) begin
                checks++;
                if (obs_q[i] !== trace[i].exp) begin
                    errors++;
                    $display("FAIL timeout_case%0d cycle %0d: got %h expected %h", s, i, obs_q[i], trace[i].exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        push_cyc(ev(0, 0, A_NONE, 0, 0), 1'b0, 1'b1, 0, 6'h2b, 6'h00);
        push_cyc(ev(1, MRD | PCW | IRW, A_NONE, 0, 0), 1'b1, 1'b1, 0, 6'h2b, 6'h00);
        push_cyc(ev(2, RRD, A_NONE, 0, 0), 1'b0, 1'b1, 1, 6'h2b, 6'h00);
        push_cyc(ev(3, ASRC, A_ADD, 0, 0), 1'b0, 1'b1, 0, 6'h2b, 6'h00);
        push_cyc(ev(4, IORD | MWR, A_ADD, 0, 0), 1'b0, 1'b1, 0, 6'h2b, 6'h00);
        push_cyc(ev(4, IORD | MWR, A_ADD, 0, 0), 1'b0, 1'b1, 0, 6'h2b, 6'h00);
        play();
        foreach (trace[i]) begin
            checks++;
            if (obs_q[i] !== trace[i].exp) begin
                errors++;
                $display("FAIL mid_mem cycle %0d: got %h expected %h", i, obs_q[i], trace[i].exp);
            end
        end
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b0; run = 1'b0;
        #1;
        checks++;
        if (obs !== ev(0, 0, A_NONE, 0, 0)) begin
            errors++;
            $display("FAIL mid_mem_reset: got %h expected %h (MemWrite=%b)", obs, ev(0, 0, A_NONE, 0, 0), MemWrite);
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; mem_ready = 1'b0; Opcode = '0; Function = '0;
        model_cnt = '0;
        test_reset();
        test_directed();
        test_random();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/mips_multicycle_sequencer.md
Name: mips_multicycle_sequencer

Overview:
- Multi-cycle control FSM for the MIPS datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB so one shared memory port serves both instruction fetch and lw/sw.
- Drives the datapath strobes that the single-cycle decoder drives, plus PC/IR write enables and a memory-address select.
- Sits between the instruction register and datapath muxes; handshakes with memory via mem_ready.

Parameters:
- MEM_WAIT_MAX, 15, max cycles to wait for mem_ready in FETCH/MEM before trapping (1..255).
- WAIT_W, 8, width of the wait counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  1 = execute instructions; 0 = stop at next instruction boundary
- Opcode  in  6  IR[31:26], valid from the cycle after IRWrite
- Function  in  6  IR[5:0], valid from the cycle after IRWrite
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  load PC (PC+4 in FETCH, target in JUMP)
- IRWrite  out  1  load instruction register
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result
- MemRead, MemWrite  out  1 each  memory strobes
- RegRead, RegWrite  out  1 each  register-file strobes
- RegDst  out  1  1 = rd, 0 = rt
- ALUsrc  out  1  1 = immediate
- MemtoReg  out  1  1 = memory data to register file
- Muxif  out  1  1 = PC source is the jump target (j or jr)
- ALU_Op  out  4  ALU operation
- state  out  4  current state, for debug
- busy  out  1  1 in any state other than IDLE/TRAP
- illegal  out  1  sticky: undecodable instruction
- timeout  out  1  sticky: memory wait exceeded
- retired_cnt  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset has priority over all other events. State goes to IDLE. All outputs are 0 except ALU_Op=4'b1111. Sticky flags and wait counter clear.
- All outputs are a registered-state Moore decode. The only exceptions are IRWrite/PCWrite in FETCH, which assert combinationally in the cycle mem_ready=1.
- IDLE: all strobes 0. run=1 → FETCH.
- FETCH: IorD=0, MemRead=1.
  - mem_ready=1 → IRWrite=1, PCWrite=1 that cycle → DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE (1 cycle): RegRead=1. Latch Opcode/Function internally; EXEC/MEM/WB use the latched copy. Then:
  - j (0x02) or jr (0x00/0x08) → JUMP.
  - add/sub/subu/and/or/nor/slt (0x00 with funct 0x20/0x22/0x23/0x24/0x25/0x27/0x2a), addi/andi/ori/slti (0x08/0x0c/0x0d/0x0a), lw (0x23), sw (0x2b) → EXEC.
  - Anything else → TRAP with illegal=1.
- EXEC (1 cycle): ALU_Op per instruction. ALUsrc=1 for I-type/lw/sw. lw/sw → MEM; all others → WB.
- MEM: IorD=1; MemRead=1 (lw) or MemWrite=1 (sw), held until mem_ready.
  - lw → WB.
  - sw retires → FETCH if run, else IDLE.
- WB (1 cycle): RegWrite=1. RegDst=1 for R-type. MemtoReg=1 for lw. Retire → FETCH if run, else IDLE.
- JUMP (1 cycle): Muxif=1, PCWrite=1. Retire → FETCH/IDLE as above.
- TRAP: all strobes 0, ALU_Op=4'b1111. Exit only by reset.
- Latency in cycles with zero memory wait: R/I-type 4, lw 5, sw 4, j/jr 3.
- Wait counter:
  - Clears on entry to FETCH/MEM.
  - Reaching MEM_WAIT_MAX with mem_ready=0 → TRAP, timeout=1.
  - mem_ready=1 on the limit cycle wins: normal completion.
- run=0 mid-instruction: the current instruction completes, then the FSM goes to IDLE. Memory strobes are never cut short.

Optional Feature:
- Macro: MIPS_SEQ_INSTR_COUNT_EN.
- Defined: retired_cnt increments by 1 on each retire event (WB exit, sw MEM exit, JUMP exit), saturates at 32'hFFFF_FFFF, reset to 0.
- Undefined: retired_cnt is tied to 0 and no counter logic exists.

Decomposition:
- Package mips_ctrl_pkg holds:
  - Opcode/funct constants.
  - ALU_Op encodings: ADD=0000, AND=0001, NOR=0011, OR=0100, SLT=0101, SUB=0111, SUBU=1000, NONE=1111.
  - State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, JUMP=6, TRAP=7.
- One sub-module, mips_seq_decode: combinational decoder mapping latched Opcode/Function to instruction class, ALU_Op, ALUsrc, RegDst, MemtoReg and legal.

Test Plan:
- add $3,$1,$2 (op 0x00, funct 0x20), mem_ready=1 → states 1,2,3,5. WB has RegWrite=1, RegDst=1, ALU_Op=0000. Back in FETCH at cycle 5.
- lw (op 0x23), 2 wait cycles in FETCH and MEM → MemRead held 3 cycles each with IorD 0 then 1. WB has MemtoReg=1, RegDst=0. Total 9 cycles.
- sw (op 0x2b) with run dropped in EXEC → MemWrite=1 in MEM, RegWrite never 1, ends in IDLE with busy=0.
- j (op 0x02) → JUMP for one cycle with Muxif=1, PCWrite=1, ALU_Op=1111, then FETCH. retired_cnt (macro on) increments 0→1.
- Opcode 0x3f → TRAP after DECODE, illegal=1 held while run toggles. Reset → IDLE, flags 0.
- mem_ready held 0 in FETCH, MEM_WAIT_MAX=4 → TRAP, timeout=1. Repeat with mem_ready=1 on the limit cycle → no trap. Reset asserted mid-MEM → next cycle IDLE, MemWrite=0.
